// File: rtl/lucknow_mem_pkg.sv
// Shared types and constants for the memory arbiter.
package lucknow_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Byte address to word index shift.
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the requester that did not win last time wins a tie.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the valids and the last winner.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] && (!valid[1] || last);
        grant[1] = valid[1] && (!valid[0] || !last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port word memory between instruction fetch (req0) and load/store (req1).
module mem_arbiter #(
    parameter int unsigned WORDS      = 64,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_addr,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    import lucknow_mem_pkg::*;

    localparam int unsigned WORD_W = DATA_WIDTH - WORD_SHIFT;

    state_t                  state;
    state_t                  next_state;
    logic                    rr_last;
    logic [1:0]              grant;
    logic                    hs;
    logic                    hs_id;
    logic                    we_q;
    logic                    ok_q;
    logic [DATA_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_we;
    logic                    sel_ok;
    logic [WORD_W-1:0]       sel_word;

    rr_arbiter2 u_rr (
        .valid ({req1_valid, req0_valid}),
        .last  (rr_last),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake readies; only the IDLE winner sees ready.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        hs_id      = REQ_FETCH;
        case (state)
            IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    hs         = 1'b1;
                    hs_id      = grant[1] ? REQ_DATA : REQ_FETCH;
                    next_state = ACCESS;
                end
            end
            ACCESS: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Mux the winning request and check alignment and range.
    always_comb begin
        sel_addr  = (hs_id == REQ_DATA) ? req1_addr : req0_addr;
        sel_wdata = (hs_id == REQ_DATA) ? req1_wdata : '0;
        sel_we    = (hs_id == REQ_DATA) && req1_we;
        sel_word  = sel_addr[DATA_WIDTH-1:WORD_SHIFT];
        sel_ok    = (sel_addr[WORD_SHIFT-1:0] == '0) && (sel_word < WORD_W'(WORDS));
    end

    // Latch the transaction, drive the memory for one ACCESS cycle, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last   <= 1'b1;
            we_q      <= 1'b0;
            ok_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_FETCH;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            if (hs) begin
                rr_last   <= hs_id;
                we_q      <= sel_we;
                ok_q      <= sel_ok;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_write <= sel_we && sel_ok;
            end
            if (state == ACCESS) begin
                rsp_valid <= 1'b1;
                rsp_id    <= rr_last;
                rsp_err   <= !ok_q;
                rsp_rdata <= (ok_q && !we_q) ? mem_rdata : '0;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64-word memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_we;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic        wr;
    } vec_t;

    vec_t vecs [14];

    mem_arbiter #(.WORDS(64), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_we    (req1_we),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One isolated transaction with rsp_ready high.
    task automatic do_txn(input vec_t v, input string name);
        int   n;
        logic rdy;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1;
            req1_addr  = v.addr;
            req1_wdata = v.wdata;
            req1_we    = v.we;
        end else begin
            req0_valid = 1'b1;
            req0_addr  = v.addr;
        end
        #1;
        rdy = v.id ? req1_ready : req0_ready;
        n = 0;
        while (!rdy && n < 8) begin
            @(negedge clk);
            #1;
            rdy = v.id ? req1_ready : req0_ready;
            n++;
        end
        chk({name, "_ready"}, 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk({name, "_wr"}, 32'(mem_write), 32'(v.wr));
        if (v.wr) chk({name, "_waddr"}, mem_addr, v.addr);
        chk({name, "_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_id"}, 32'(rsp_id), 32'(v.id));
        chk({name, "_err"}, 32'(rsp_err), 32'(v.err));
        chk({name, "_rdata"}, rsp_rdata, v.rdata);
        chk({name, "_wr_resp"}, 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] h_rdata;
        logic        h_id;
        logic        h_err;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0006, 32'hBAD0_BAD0, 1'b1, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h8000_0008, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0,         1'b0};

        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = 32'h0;
        req1_valid = 1'b0;
        req1_addr  = 32'h0;
        req1_wdata = 32'h0;
        req1_we    = 1'b0;
        rsp_ready  = 1'b0;

        // Reset then idle.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_ctrl", {26'h0, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, mem_write}, 32'h0);
            chk("reset_rdata", rsp_rdata, 32'h0);
            chk("reset_maddr", mem_addr | mem_wdata, 32'h0);
        end

        // Directed single transactions.
        for (int i = 0; i < 14; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous contention: grants alternate 0,1,0,1 every third cycle.
        @(negedge clk);
        rsp_ready  = 1'b1;
        req0_addr  = 32'h0000_0000;
        req1_addr  = 32'h0000_0004;
        req1_we    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] exp_g;
            #1;
            exp_g = 2'b00;
            if (i % 3 == 0) exp_g = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
            chk($sformatf("rr_grant_c%0d", i), 32'({req1_ready, req0_ready}), 32'(exp_g));
            chk($sformatf("rr_rspv_c%0d", i), 32'(rsp_valid), 32'(i % 3 == 2));
            if (i % 3 == 2) begin
                chk($sformatf("rr_id_c%0d", i), 32'(rsp_id), 32'((i / 3) % 2));
                chk($sformatf("rr_rdata_c%0d", i), rsp_rdata,
                    ((i / 3) % 2 == 1) ? 32'h1234_5678 : 32'h1111_1111);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        // Back-pressure: response held for 4 cycles with rsp_ready low.
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_0008;
        #1;
        chk("bp_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_0004;
        req1_we    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        h_rdata = rsp_rdata;
        h_id    = rsp_id;
        h_err   = rsp_err;
        chk("bp_rdata", h_rdata, 32'hDEAD_BEEF);
        chk("bp_id", 32'(h_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", {rsp_rdata[31:3], rsp_valid, rsp_id, rsp_err}, {h_rdata[31:3], 1'b1, h_id, h_err});
            chk("bp_hold_lsb", 32'(rsp_rdata[2:0]), 32'(h_rdata[2:0]));
            chk("bp_readies", 32'({req1_ready, req0_ready}), 32'd0);
            if (i < 3) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req1_ready), 32'd1);
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_no_txn", {29'h0, rsp_valid, mem_write, req1_ready}, 32'h0);
        end

        // Asynchronous reset during the ACCESS cycle of a store.
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_0010;
        req1_wdata = 32'h7777_7777;
        req1_we    = 1'b1;
        #1;
        chk("rst_hs_ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rst_access_wr", 32'(mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_wr", 32'(mem_write), 32'd0);
        chk("rst_async_rspv", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", {30'h0, rsp_valid, mem_write}, 32'h0);
        end
        do_txn('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 1'b0}, "rst_after_read");
        do_txn('{1'b0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0}, "rst_after_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
